led_run_ctrl: RTL and testbench

Running-light scheduler for an N-wide LED bank. One shared step timer paces the sequence. Each step, a single position index selects which LED is lit, for the first T_ON cycles of that step. The block sits between board-level control inputs (start/stop/direction/mode) and the LED pins, replacing per-LED free-running pulse modules with one sequenced controller.

---
 rtl/led_run_pkg.sv | 19 +
 rtl/led_step_timer.sv | 30 +++
 rtl/led_run_ctrl.sv | 138 +++++++++++++
 tb/tb_led_run_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/led_run_pkg.sv
// Shared types and constants for the running-light controller.
package led_run_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DN      = 1'b1;
    localparam logic MODE_CHASE  = 1'b0;
    localparam logic MODE_BOUNCE = 1'b1;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/led_step_timer.sv
// Shared step timer: counts 0..T_STEP and flags the last cycle of each step.
module led_step_timer
    import led_run_pkg::*;
#(
    parameter int unsigned T_STEP = 20,
    localparam int unsigned CW = cnt_width(T_STEP)
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          En,
    input  logic          Clr,
    output logic [CW-1:0] Count,
    output logic          Tick
);

    // Wrap counter; held at zero while cleared.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            Count <= '0;
        end else if (Clr) begin
            Count <= '0;
        end else if (En) begin
            Count <= (Count == CW'(T_STEP)) ? '0 : Count + CW'(1);
        end
    end

    // Step boundary decoded purely from the count register.
    assign Tick = En && (Count == CW'(T_STEP));

endmodule

// File: rtl/led_run_ctrl.sv
// Running-light scheduler: one step timer, one lit LED per step, chase or bounce.
module led_run_ctrl
    import led_run_pkg::*;
#(
    parameter int unsigned N_LED  = 4,
    parameter int unsigned T_STEP = 20,
    parameter int unsigned T_ON   = 5
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Dir,
    input  logic             Mode,
    output logic [N_LED-1:0] LED_Out,
    output logic             Busy,
    output logic             Step_Tick
);

    localparam int unsigned CW = cnt_width(T_STEP);
    localparam int unsigned PW = cnt_width(N_LED - 1);
    localparam logic [PW-1:0] POS_MAX = PW'(N_LED - 1);

    state_t            state_q, state_d;
    logic [PW-1:0]     pos_q, pos_d, pos_adv;
    logic              dir_q, dir_d, dir_adv;
    logic              mode_q, mode_d;
    logic              stop_pend_q, stop_pend_d;
    logic [N_LED-1:0]  led_d;
    logic [CW-1:0]     count;
    logic              boundary;
    logic              lit;

    led_step_timer #(.T_STEP(T_STEP)) u_timer (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .En    (state_q == ST_RUN),
        .Clr   (state_q == ST_IDLE),
        .Count (count),
        .Tick  (boundary)
    );

    assign Busy      = (state_q == ST_RUN);
    assign Step_Tick = boundary;
    assign lit       = 32'(count) < T_ON;

    // Next position/direction at a step boundary for the captured mode.
    always_comb begin
        pos_adv = pos_q;
        dir_adv = dir_q;
        if (N_LED == 1) begin
            pos_adv = '0;
        end else if (mode_q == MODE_CHASE) begin
            if (dir_q == DIR_UP) begin
                pos_adv = (pos_q == POS_MAX) ? '0 : pos_q + PW'(1);
            end else begin
                pos_adv = (pos_q == '0) ? POS_MAX : pos_q - PW'(1);
            end
        end else begin
            // Bounce turns around at an end without repeating the endpoint.
            if (dir_q == DIR_UP) begin
                if (pos_q == POS_MAX) begin
                    dir_adv = DIR_DN;
                    pos_adv = pos_q - PW'(1);
                end else begin
                    pos_adv = pos_q + PW'(1);
                end
            end else begin
                if (pos_q == '0) begin
                    dir_adv = DIR_UP;
                    pos_adv = pos_q + PW'(1);
                end else begin
                    pos_adv = pos_q - PW'(1);
                end
            end
        end
    end

    // FSM next state, sequence registers and LED drive.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        dir_d       = dir_q;
        mode_d      = mode_q;
        stop_pend_d = stop_pend_q;
        led_d       = '0;
        for (int i = 0; i < int'(N_LED); i++) begin
            led_d[i] = (state_q == ST_RUN) && (pos_q == PW'(i)) && lit;
        end
        case (state_q)
            ST_IDLE: begin
                if (Start && !Stop) begin
                    state_d     = ST_RUN;
                    pos_d       = (Dir == DIR_DN) ? POS_MAX : '0;
                    dir_d       = Dir;
                    mode_d      = Mode;
                    stop_pend_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (Stop) begin
                    stop_pend_d = 1'b1;
                end
                if (boundary) begin
                    if (stop_pend_q || Stop) begin
                        state_d     = ST_IDLE;
                        pos_d       = '0;
                        stop_pend_d = 1'b0;
                    end else begin
                        pos_d = pos_adv;
                        dir_d = dir_adv;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            pos_q       <= '0;
            dir_q       <= 1'b0;
            mode_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            LED_Out     <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            mode_q      <= mode_d;
            stop_pend_q <= stop_pend_d;
            LED_Out     <= led_d;
        end
    end

endmodule

// File: tb/tb_led_run_ctrl.sv
// Directed bench for led_run_ctrl: four parameterisations driven in lockstep.
module tb_led_run_ctrl;

    localparam int PER = 21;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic       d;
        logic       busy;
        logic       tick;
    } exp_t;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    logic Start = 1'b0;
    logic Stop = 1'b0;
    logic Dir = 1'b0;
    logic Mode = 1'b0;

    logic [3:0] led_a, led_b, led_c;
    logic [0:0] led_d;
    logic busy_a, busy_b, busy_c, busy_d;
    logic tick_a, tick_b, tick_c, tick_d;

    exp_t sb[$];
    int   seq [0:7];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cur_t = 0;

    led_run_ctrl #(.N_LED(4), .T_STEP(20), .T_ON(5)) u_a (
        .CLK(CLK), .RSTn(RSTn), .Start(Start), .Stop(Stop), .Dir(Dir), .Mode(Mode),
        .LED_Out(led_a), .Busy(busy_a), .Step_Tick(tick_a));
    led_run_ctrl #(.N_LED(4), .T_STEP(20), .T_ON(0)) u_b (
        .CLK(CLK), .RSTn(RSTn), .Start(Start), .Stop(Stop), .Dir(Dir), .Mode(Mode),
        .LED_Out(led_b), .Busy(busy_b), .Step_Tick(tick_b));
    led_run_ctrl #(.N_LED(4), .T_STEP(20), .T_ON(21)) u_c (
        .CLK(CLK), .RSTn(RSTn), .Start(Start), .Stop(Stop), .Dir(Dir), .Mode(Mode),
        .LED_Out(led_c), .Busy(busy_c), .Step_Tick(tick_c));
    led_run_ctrl #(.N_LED(1), .T_STEP(20), .T_ON(5)) u_d (
        .CLK(CLK), .RSTn(RSTn), .Start(Start), .Stop(Stop), .Dir(Dir), .Mode(Mode),
        .LED_Out(led_d), .Busy(busy_d), .Step_Tick(tick_d));

    always #5 CLK = ~CLK;

    function automatic exp_t idle_exp();
        exp_t e;
        e = '0;
        return e;
    endfunction

    // Expected outputs t cycles after Busy rose; tlast is the final Busy cycle.
    function automatic exp_t run_exp(input int t, input int tlast);
        exp_t e;
        int   p;
        int   c;
        e      = '0;
        e.busy = (t <= tlast);
        e.tick = (t <= tlast) && ((t % PER) == PER - 1);
        if (t >= 1 && t <= tlast + 1) begin
            p   = seq[(t - 1) / PER];
            c   = (t - 1) % PER;
            e.c = 4'b0001 << p;
            if (c < 5) begin
                e.a = 4'b0001 << p;
                e.d = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic cmp(input string name, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s t=%0d observed=%h expected=%h", name, cur_t, obs, exp);
    endtask

    task automatic check(input string tag);
        exp_t e;
        n_checks++;
        assert (sb.size() > 0) n_pass++;
        else $error("FAIL %s t=%0d observed=empty expected=entry", tag, cur_t);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp({tag, ".led_a"}, led_a, e.a);
            cmp({tag, ".led_b"}, led_b, e.b);
            cmp({tag, ".led_c"}, led_c, e.c);
            cmp({tag, ".led_d"}, {3'b000, led_d}, {3'b000, e.d});
            cmp({tag, ".busy_a"}, {3'b000, busy_a}, {3'b000, e.busy});
            cmp({tag, ".busy_b"}, {3'b000, busy_b}, {3'b000, e.busy});
            cmp({tag, ".busy_c"}, {3'b000, busy_c}, {3'b000, e.busy});
            cmp({tag, ".busy_d"}, {3'b000, busy_d}, {3'b000, e.busy});
            cmp({tag, ".tick_a"}, {3'b000, tick_a}, {3'b000, e.tick});
            cmp({tag, ".tick_b"}, {3'b000, tick_b}, {3'b000, e.tick});
            cmp({tag, ".tick_c"}, {3'b000, tick_c}, {3'b000, e.tick});
            cmp({tag, ".tick_d"}, {3'b000, tick_d}, {3'b000, e.tick});
        end
    endtask

    task automatic idle_cycle(input string tag);
        sb.push_back(idle_exp());
        @(negedge CLK);
        check(tag);
    endtask

    // One run after Start has been driven; Stop sampled in cycle tstop.
    task automatic run(input string tag, input int tstop, input int glitch_t,
                       input bit restart, input bit rdir, input bit rmode);
        int tlast;
        tlast = (tstop / PER) * PER + PER - 1;
        for (int t = 0; t <= tlast + 1; t++) begin
            sb.push_back(run_exp(t, tlast));
            @(negedge CLK);
            cur_t = t;
            check(tag);
            if (t == 0) Start = 1'b0;
            if (t == glitch_t) begin
                Start = 1'b1;
                Dir   = 1'b1;
                Mode  = 1'b1;
            end
            if (t == glitch_t + 1) Start = 1'b0;
            if (t == tstop) Stop = 1'b1;
            if (t == tstop + 1) Stop = 1'b0;
            if (t == tlast + 1 && restart) begin
                Start = 1'b1;
                Dir   = rdir;
                Mode  = rmode;
            end
        end
    endtask

    initial begin
        RSTn = 1'b0;
        repeat (2) @(negedge CLK);
        idle_cycle("reset");

        // Start and Stop together in IDLE: Stop wins.
        RSTn  = 1'b1;
        Start = 1'b1;
        Stop  = 1'b1;
        repeat (3) idle_cycle("start_stop_idle");

        // Chase up, Start glitch with Dir/Mode changed mid-run, Stop at Count=3 of Pos=2.
        Stop  = 1'b0;
        Start = 1'b1;
        Dir   = 1'b0;
        Mode  = 1'b0;
        seq   = '{0, 1, 2, 3, 0, 1, 2, 0};
        run("chase_up", 6 * PER + 3, 30, 1'b1, 1'b1, 1'b1);

        // Back-to-back bounce down; Stop arrives in the boundary cycle itself.
        seq = '{3, 2, 1, 0, 1, 2, 3, 2};
        run("bounce_dn", 7 * PER + 20, -1, 1'b0, 1'b0, 1'b0);
        repeat (2) idle_cycle("after_stop");

        // Reset asserted mid-step at Count=7.
        Start = 1'b1;
        Dir   = 1'b0;
        Mode  = 1'b0;
        seq   = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int t = 0; t <= 7; t++) begin
            sb.push_back(run_exp(t, 1000));
            @(negedge CLK);
            cur_t = t;
            check("pre_reset");
            if (t == 0) Start = 1'b0;
        end
        RSTn = 1'b0;
        #1;
        sb.push_back(idle_exp());
        check("reset_mid");
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (2) idle_cycle("post_reset_idle");

        // Fresh run after reset release starts from Count=0, Pos=0.
        Start = 1'b1;
        run("post_reset", 3, -1, 1'b0, 1'b0, 1'b0);
        idle_cycle("final_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
